ultrasonic_scheduler: RTL

Round-robin controller that shares one measurement engine between up to four HC-SR04 sensors (front/left/right by default). It triggers one sensor at a time and times that sensor's echo with a shared counter, using a divide-free cm prescaler. It then publishes per-sensor distances and maintains a hysteretic obstacle mask, which feeds the motor stop logic. Sequencing prevents cross-talk: only one sensor is ever in flight.

---
 rtl/ultrasonic_scheduler.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/ultrasonic_scheduler.sv
// rtl/ultrasonic_scheduler.sv - round-robin HC-SR04 scheduler sharing one echo timer
// Triggers one enabled sensor per slot, times its echo in cm, publishes distance and obstacle flags.
module ultrasonic_scheduler #(
    parameter int NUM_SENSORS = 3,
    parameter int TRIG_CYCLES = 120,
    parameter int CYC_PER_CM  = 696,
    parameter int MAX_CM      = 400,
    parameter int ECHO_WAIT   = 360000,
    parameter int GAP_CYCLES  = 720000,
    parameter int STOP_CM     = 20,
    parameter int HYST_CM     = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [NUM_SENSORS-1:0]      sensor_en,
    input  logic [NUM_SENSORS-1:0]      echo,
    output logic [NUM_SENSORS-1:0]      trig,
    output logic [16*NUM_SENSORS-1:0]   dist_bus,
    output logic                        meas_valid,
    output logic [1:0]                  meas_idx,
    output logic [15:0]                 meas_dist,
    output logic                        meas_timeout,
    output logic [NUM_SENSORS-1:0]      obstacle,
    output logic                        obstacle_stop,
    output logic                        busy
);

    typedef enum logic [2:0] {IDLE, SELECT, TRIG, WAIT, MEASURE, PUBLISH, GAP} state_t;

    state_t                 state, next_state;
    logic [NUM_SENSORS-1:0] echo_s1, echo_s2, sel_onehot, trig_next;
    logic                   echo_sel, echo_d, echo_rise, echo_fall;
    logic                   en_sel, cm_tick;
    logic [1:0]             idx, idx_inc;
    logic [31:0]            cnt;
    logic [15:0]            pre, cm, pub_dist;
    logic                   pub_timeout;

    assign sel_onehot = NUM_SENSORS'(1) << idx;
    assign en_sel     = |(sensor_en & sel_onehot);
    assign echo_sel   = |(echo_s2 & sel_onehot);
    assign echo_rise  = echo_sel & ~echo_d;
    assign echo_fall  = ~echo_sel & echo_d;
    assign idx_inc    = (idx == 2'(NUM_SENSORS - 1)) ? 2'd0 : idx + 2'd1;
    assign cm_tick    = echo_sel && (pre == 16'(CYC_PER_CM - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state  = state;
        pub_dist    = cm;
        pub_timeout = 1'b0;
        case (state)
            IDLE:    if (enable && |sensor_en) next_state = SELECT;
            SELECT: begin
                if (!(|sensor_en)) next_state = IDLE;
                else if (en_sel)   next_state = TRIG;
            end
            TRIG:    if (cnt == 32'(TRIG_CYCLES - 1)) next_state = WAIT;
            WAIT: begin
                if (echo_rise) begin
                    next_state = MEASURE;
                end else if (cnt == 32'(ECHO_WAIT - 1)) begin
                    next_state  = PUBLISH;
                    pub_dist    = 16'(MAX_CM);
                    pub_timeout = 1'b1;
                end
            end
            MEASURE: begin
                if (echo_fall) begin
                    next_state = PUBLISH;
                end else if (cm_tick && cm == 16'(MAX_CM - 1)) begin
                    // saturate without waiting for the rest of a long echo
                    next_state = PUBLISH;
                    pub_dist   = 16'(MAX_CM);
                end
            end
            PUBLISH: next_state = GAP;
            GAP: begin
                if (cnt == 32'(GAP_CYCLES - 1))
                    next_state = (enable && |sensor_en) ? SELECT : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy          = (state != IDLE);
        obstacle_stop = |obstacle;
        trig_next     = (next_state == TRIG) ? sel_onehot : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            echo_s1      <= '0;
            echo_s2      <= '0;
            echo_d       <= 1'b0;
            cnt          <= '0;
            idx          <= '0;
            pre          <= '0;
            cm           <= '0;
            trig         <= '0;
            meas_valid   <= 1'b0;
            meas_idx     <= '0;
            meas_dist    <= '0;
            meas_timeout <= 1'b0;
            dist_bus     <= '0;
            obstacle     <= '0;
        end else begin
            echo_s1    <= echo;
            echo_s2    <= echo_s1;
            echo_d     <= echo_sel;
            cnt        <= (next_state != state) ? 32'd0 : cnt + 32'd1;
            trig       <= trig_next;
            meas_valid <= (next_state == PUBLISH);

            if ((state == SELECT && next_state == SELECT) || (state == GAP && next_state != GAP))
                idx <= idx_inc;

            // the rise cycle itself is the first echo-high cycle counted
            if (state == WAIT && echo_rise) begin
                pre <= 16'd1;
                cm  <= '0;
            end else if (state == MEASURE && echo_sel) begin
                if (cm_tick) begin
                    pre <= '0;
                    cm  <= cm + 16'd1;
                end else begin
                    pre <= pre + 16'd1;
                end
            end

            if (next_state == PUBLISH) begin
                meas_idx     <= idx;
                meas_dist    <= pub_dist;
                meas_timeout <= pub_timeout;
                for (int i = 0; i < NUM_SENSORS; i++) begin
                    if (idx == 2'(i)) begin
                        dist_bus[16*i +: 16] <= pub_dist;
                        if (pub_timeout)
                            obstacle[i] <= 1'b0;
                        else if (pub_dist < 16'(STOP_CM))
                            obstacle[i] <= 1'b1;
                        else if (pub_dist >= 16'(STOP_CM + HYST_CM))
                            obstacle[i] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
